cla32_keylocked: RTL and testbench
==================================

Name: cla32_keylocked

Overview:
- 32-bit unsigned carry-lookahead adder, hardened with 64-bit AND/OR key-gate logic locking.
- Produces the correct 33-bit sum only when the 64-bit key equals the embedded secret key; any other key deterministically corrupts the carry network.
- Leaf arithmetic block inside the locked-datapath evaluation designs; result is registered, latency 1.

Parameters:
- WIDTH, 32, operand width (fixed; the key mapping below assumes 32).
- SECRET_KEY, 64'hED06C024C5BF39E2, correct unlock key. Determines the gate type per key bit.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- add1_i  input  32  operand A, unsigned.
- add2_i  input  32  operand B, unsigned.
- keyinput  input  64  unlock key.
- valid_i  input  1  operands valid this cycle.
- result_o  output  33  registered sum; bit 32 is the carry-out.
- valid_o  output  1  result_o holds a new result.

Behaviour:
- Raw signals per bit i (0..31): g[i] = A[i] & B[i]; p[i] = A[i] ^ B[i]. Carry-in c[0] = 0.
- Key gates:
  - Generate lock: keyinput[i] locks g[i] for i = 0..31.
  - Propagate lock: keyinput[32+j] locks p[j] for j = 0..31.
  - If SECRET_KEY bit = 1, the gate is AND: locked = raw & key bit.
  - If SECRET_KEY bit = 0, the gate is OR: locked = raw | key bit.
  - With the correct key every gate is transparent.
  - With a wrong bit, the locked signal is forced to 0 (AND-type) or 1 (OR-type).
- Carry network:
  - Uses only the locked gl and pl: 8 groups of 4-bit lookahead.
  - Group generate and propagate feed a second-level lookahead unit that produces group carries.
  - c[i+1] = gl[i] | (pl[i] & c[i]), computed in lookahead form. No ripple chain longer than 4 bits.
- Outputs: sum[i] = pl[i] ^ c[i]; result bit 32 = c[32].
- Correct key: result_o = zero-extended add1_i + add2_i, mod 2^33. No overflow loss.
- Timing:
  - Inputs are sampled on the clock edge where valid_i = 1.
  - result_o and valid_o update on that edge, so they are valid in the following cycle.
  - When valid_i = 0, result_o holds its value and valid_o = 0.
- Reset: on a rising edge with rst = 1, result_o = 0 and valid_o = 0. Reset overrides valid_i in the same cycle.
- Key changes take effect on the next sampled operation. No key latching.
- No X propagation: all 64 key bits are used; none are unconnected.

Optional Feature:
- Macro CLA_KEY_CHECK_EN.
- Defined:
  - Adds output key_ok_o (1 bit), registered alongside result_o.
  - key_ok_o = 1 when keyinput == SECRET_KEY at the sampled edge.
  - key_ok_o resets to 0 and holds its value when valid_i = 0.
- Not defined: port absent; no comparator logic.

Test Plan:
1. Reset: rst = 1 for 2 cycles with valid_i = 1 -> result_o = 0, valid_o = 0; after release, the first valid result appears 1 cycle later.
2. Correct key ED06C024C5BF39E2:
   - A = FFFFFFFF, B = 00000001 -> result_o = 1_00000000.
   - A = 12345678, B = 87654321 -> 0_99999999.
   - A = B = FFFFFFFF -> 1_FFFFFFFE.
3. Generate-lock corruption: key ED06C024C5BF39E0 (bit 1 = 0 on an AND gate), A = 2, B = 2 -> result_o = 0 (correct value is 4).
4. Propagate-lock corruption: key CD06C024C5BF39E2 (bit 61 = 0 on an AND gate), A = 20000000, B = 0 -> result_o = 0.
5. OR-gate corruption: key ED06C024C5BF39E3 (bit 0 = 1 on an OR gate), A = 0, B = 0 -> result_o = 2 (g[0] forced to 1).
6. Random regression: 10000 random pairs under the correct key -> exact sum every cycle, latency 1. Under keys at Hamming distance 1-6 from the secret -> compare against a golden model of the gate rules above; mismatches versus the true sum must be nonzero.

Source files
------------

// File: rtl/cla32_keylocked_if.sv
// Operand/key/result bundle for the key-locked 32-bit carry-lookahead adder.
// The key_ok_o signal exists only when CLA_KEY_CHECK_EN is defined.
interface cla32_keylocked_if;
   logic [31:0] add1_i;
   logic [31:0] add2_i;
   logic [63:0] keyinput;
   logic        valid_i;
   logic [32:0] result_o;
   logic        valid_o;
`ifdef CLA_KEY_CHECK_EN
   logic        key_ok_o;

   modport master (
      output add1_i, add2_i, keyinput, valid_i,
      input  result_o, valid_o, key_ok_o
   );
   modport slave (
      input  add1_i, add2_i, keyinput, valid_i,
      output result_o, valid_o, key_ok_o
   );
`else
   modport master (
      output add1_i, add2_i, keyinput, valid_i,
      input  result_o, valid_o
   );
   modport slave (
      input  add1_i, add2_i, keyinput, valid_i,
      output result_o, valid_o
   );
`endif
endinterface

// File: rtl/cla32_keylocked.sv
// 32-bit unsigned two-level carry-lookahead adder with 64-bit AND/OR key-gate locking.
// keyinput[31:0] gates the per-bit generates, keyinput[63:32] the per-bit propagates.
// A SECRET_KEY bit of 1 selects an AND gate, 0 an OR gate, so only the secret key is
// transparent. Registered result, latency 1.
// Optional: define CLA_KEY_CHECK_EN to add a registered key_ok_o flag.
module cla32_keylocked #(
   parameter int unsigned WIDTH      = 32,
   parameter logic [63:0] SECRET_KEY = 64'hED06C024C5BF39E2
) (
   input logic              clk,
   input logic              rst,
   cla32_keylocked_if.slave bus
);

   logic [WIDTH-1:0] g, p, gl, pl, sum;
   logic [WIDTH:0]   c;
   logic [7:0]       gg, gp;
   logic [8:0]       cg;
   logic             term;
   logic [WIDTH:0]   result_d, result_q;
   logic             valid_q;

   // Raw generate/propagate followed by the key gates (AND where secret bit is 1, else OR)
   always_comb begin
      g  = bus.add1_i & bus.add2_i;
      p  = bus.add1_i ^ bus.add2_i;
      gl = (g & bus.keyinput[31:0] & SECRET_KEY[31:0])
         | ((g | bus.keyinput[31:0]) & ~SECRET_KEY[31:0]);
      pl = (p & bus.keyinput[63:32] & SECRET_KEY[63:32])
         | ((p | bus.keyinput[63:32]) & ~SECRET_KEY[63:32]);
   end

   // Two-level lookahead: 4-bit group G/P, sum-of-products group carries, in-group carries
   always_comb begin
      gg   = '0;
      gp   = '0;
      cg   = '0;
      c    = '0;
      term = 1'b0;
      for (int k = 0; k < 8; k++) begin
         gg[k] = gl[4*k+3]
               | (pl[4*k+3] & gl[4*k+2])
               | (pl[4*k+3] & pl[4*k+2] & gl[4*k+1])
               | (pl[4*k+3] & pl[4*k+2] & pl[4*k+1] & gl[4*k]);
         gp[k] = &pl[4*k +: 4];
      end
      // cg[0] is the adder carry-in, tied to 0
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j <= k; j++) begin
            term = gg[j];
            for (int t = j + 1; t <= k; t++) begin
               term = term & gp[t];
            end
            cg[k+1] = cg[k+1] | term;
         end
      end
      for (int k = 0; k < 8; k++) begin
         c[4*k]   = cg[k];
         c[4*k+1] = gl[4*k] | (pl[4*k] & cg[k]);
         c[4*k+2] = gl[4*k+1] | (pl[4*k+1] & gl[4*k])
                  | (pl[4*k+1] & pl[4*k] & cg[k]);
         c[4*k+3] = gl[4*k+2] | (pl[4*k+2] & gl[4*k+1])
                  | (pl[4*k+2] & pl[4*k+1] & gl[4*k])
                  | (pl[4*k+2] & pl[4*k+1] & pl[4*k] & cg[k]);
      end
      c[WIDTH] = cg[8];
   end

   // Sum bits and carry-out
   always_comb begin
      sum      = pl ^ c[WIDTH-1:0];
      result_d = {c[WIDTH], sum};
   end

   // Result register: loads on valid_i, holds otherwise; reset wins over valid_i
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= bus.valid_i;
         if (bus.valid_i) begin
            result_q <= result_d;
         end
      end
   end

   assign bus.result_o = result_q;
   assign bus.valid_o  = valid_q;

`ifdef CLA_KEY_CHECK_EN
   logic key_ok_q;

   // Key-match flag registered alongside the result
   always_ff @(posedge clk) begin
      if (rst) begin
         key_ok_q <= 1'b0;
      end else if (bus.valid_i) begin
         key_ok_q <= (bus.keyinput == SECRET_KEY);
      end
   end

   assign bus.key_ok_o = key_ok_q;
`endif

endmodule

// File: tb/tb_cla32_keylocked.sv
// Self-checking bench for cla32_keylocked: directed cases, random correct-key sums and
// random near-miss keys checked against a bit-serial model of the key-gate rules.
module tb_cla32_keylocked;

   localparam logic [63:0] SECRET = 64'hED06C024C5BF39E2;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   int   mism;

   cla32_keylocked_if bus ();

   cla32_keylocked #(
      .WIDTH      (32),
      .SECRET_KEY (SECRET)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: apply key-gate rules per bit, then a plain carry recurrence
   function automatic logic [32:0] golden(input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] key);
      logic [63:0] s;
      logic [32:0] r;
      logic        cy, gi, pi;
      s  = SECRET;
      cy = 1'b0;
      r  = '0;
      for (int i = 0; i < 32; i++) begin
         gi = a[i] & b[i];
         pi = a[i] ^ b[i];
         gi = s[i]    ? (gi & key[i])    : (gi | key[i]);
         pi = s[32+i] ? (pi & key[32+i]) : (pi | key[32+i]);
         r[i] = pi ^ cy;
         cy   = gi | (pi & cy);
      end
      r[32] = cy;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] key, input logic [32:0] exp);
      bus.add1_i   = a;
      bus.add2_i   = b;
      bus.keyinput = key;
      bus.valid_i  = 1'b1;
      step();
      check(tag, bus.result_o, exp);
      check({tag, "_valid"}, {32'd0, bus.valid_o}, 33'd1);
`ifdef CLA_KEY_CHECK_EN
      check({tag, "_keyok"}, {32'd0, bus.key_ok_o}, {32'd0, key == SECRET});
`endif
   endtask

   initial begin
      logic [31:0] a, b;
      logic [63:0] key, s;
      logic [32:0] exp;
      int          n, pos;
      tests = 0;
      fails = 0;
      mism  = 0;
      s     = SECRET;

      // Reset with valid_i high: reset must win
      rst          = 1'b1;
      bus.valid_i  = 1'b1;
      bus.add1_i   = 32'h5;
      bus.add2_i   = 32'h7;
      bus.keyinput = SECRET;
      repeat (2) begin
         step();
         check("reset_result", bus.result_o, 33'd0);
         check("reset_valid", {32'd0, bus.valid_o}, 33'd0);
      end
      rst = 1'b0;

      do_op("first_after_reset", 32'hFFFFFFFF, 32'h00000001, SECRET, 33'h1_00000000);

      // valid_i low: result holds, valid_o drops
      bus.valid_i = 1'b0;
      bus.add1_i  = 32'h0;
      bus.add2_i  = 32'h0;
      step();
      check("hold_result", bus.result_o, 33'h1_00000000);
      check("hold_valid", {32'd0, bus.valid_o}, 33'd0);

      do_op("sum_mixed", 32'h12345678, 32'h87654321, SECRET, 33'h0_99999999);
      do_op("sum_max", 32'hFFFFFFFF, 32'hFFFFFFFF, SECRET, 33'h1_FFFFFFFE);
      do_op("glock_and", 32'h2, 32'h2, 64'hED06C024C5BF39E0, 33'h0);
      do_op("plock_and", 32'h20000000, 32'h0, 64'hCD06C024C5BF39E2, 33'h0);
      do_op("glock_or", 32'h0, 32'h0, 64'hED06C024C5BF39E3, 33'h2);
      do_op("back_to_key", 32'h2, 32'h2, SECRET, 33'h4);

      // Random operands, correct key: plain arithmetic sum
      for (int i = 0; i < 10000; i++) begin
         a = $urandom;
         b = $urandom;
         if (i % 16 == 0) a = 32'hFFFFFFFF;
         do_op("rand_ok", a, b, SECRET, {1'b0, a} + {1'b0, b});
      end

      // Random operands, keys at Hamming distance 1..6 from the secret
      for (int i = 0; i < 1200; i++) begin
         n   = 1 + (i % 6);
         key = SECRET;
         while ($countones(key ^ s) < n) begin
            pos = $urandom_range(63, 0);
            if (key[pos] == s[pos]) key[pos] = ~key[pos];
         end
         a   = $urandom;
         b   = $urandom;
         exp = golden(a, b, key);
         do_op("rand_badkey", a, b, key, exp);
         if (bus.result_o !== ({1'b0, a} + {1'b0, b})) mism++;
      end
      tests++;
      assert (mism != 0) else begin
         fails++;
         $error("FAIL badkey_corrupts: observed %0d mismatches expected nonzero", mism);
      end

      // Mid-stream reset with valid_i high
      rst         = 1'b1;
      bus.valid_i = 1'b1;
      step();
      check("reset_mid_result", bus.result_o, 33'd0);
      check("reset_mid_valid", {32'd0, bus.valid_o}, 33'd0);
      rst = 1'b0;
      do_op("after_mid_reset", 32'h80000000, 32'h80000000, SECRET, 33'h1_00000000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
